multdiv_sequencer: RTL and testbench
====================================

// Module: multdiv_sequencer
// PURPOSE
//  Control stage that consumes a 6-bit iteration count to sequence a 32-step
//  iterative multiply/divide datapath. Sits downstream of the ctrl_MULT/ctrl_DIV
//  start pulses and upstream of the shift/add datapath, which it drives.
//  Emits load, per-step enable, operation select and a one-cycle result-ready.
// PARAMETERS
//  N_STEPS  32  datapath iterations per operation; 2 <= N_STEPS <= 2**CNT_W
//  CNT_W    6   iteration counter width
// PORTS
//  clk        in   1      clock; all state updates on posedge clk
//  clr        in   1      reset: synchronous, active-high
//  ctrl_mult  in   1      start-multiply pulse
//  ctrl_div   in   1      start-divide pulse
//  busy       out  1      high in LOAD and RUN
//  load       out  1      one-cycle pulse: datapath captures operands
//  step       out  1      datapath advance enable, high every RUN cycle
//  is_div     out  1      latched op: 0 = multiply, 1 = divide
//  count      out  CNT_W  current iteration index (0 .. N_STEPS-1)
//  result_rdy out  1      one-cycle pulse: datapath result valid
//  start_err  out  1      one-cycle pulse: ctrl_mult and ctrl_div both high
// BEHAVIOUR
//  Reset: clr high at a posedge -> state IDLE, count 0, is_div 0, all pulses 0.
//   clr beats every other input, including a simultaneous start.
//  Outputs are registered, decoded from state: load = (LOAD), step = (RUN),
//   busy = (LOAD|RUN), result_rdy = (DONE).
//  States, 2-bit encoding: IDLE=00 LOAD=01 RUN=10 DONE=11.
//  start = ctrl_mult ^ ctrl_div. If both are high: no state change, no is_div
//   update, start_err = 1 next cycle.
//  IDLE: start -> LOAD; is_div <= ctrl_div.
//  LOAD: count <= 0; -> RUN.
//  RUN: count <= count+1 each cycle. When count == N_STEPS-1 -> DONE; count holds.
//  DONE: -> IDLE. A start in DONE -> LOAD (back-to-back, no IDLE bubble).
//  Start while in LOAD or RUN: abort, -> LOAD, re-latch is_div. No result_rdy
//   for the aborted operation.
//  Latency: start sampled at cycle 0 -> load at 1, step at 2..N_STEPS+1,
//   result_rdy at N_STEPS+2 (34 for N_STEPS = 32).
//  step is high for exactly N_STEPS cycles per uninterrupted op, with count
//   0..N_STEPS-1 on consecutive step cycles.
//  count never wraps: it is cleared only in LOAD and by clr, and saturates at
//   N_STEPS-1.
//  Inputs are pulses; a start held high is re-sampled every cycle, so every
//   held-high cycle re-enters LOAD.
// STRUCTURE
//  Shared package/include: state encodings (S_IDLE..S_DONE), N_STEPS_DEFAULT=32,
//   CNT_W_DEFAULT=6.
//  One sub-module: iter_counter -- CNT_W-bit up-counter with synchronous clear,
//   enable and terminal-count flag (tc = count==N_STEPS-1). The FSM uses tc
//   for the RUN->DONE transition.
//  FSM next-state logic and output registers stay in multdiv_sequencer.
// TESTING
//  1 clr for 2 cycles, then idle 5 cycles -> busy/load/step/result_rdy/start_err
//    all 0, count 0.
//  2 ctrl_mult pulse at cycle 0 -> load at 1; step at 2..33 with count 0..31;
//    result_rdy at 34 only; is_div 0.
//  3 ctrl_div pulse, then a second ctrl_div pulse in the DONE cycle -> is_div 1,
//    second load the cycle after DONE, second result_rdy 33 cycles after it.
//  4 ctrl_mult, then ctrl_div when count==10 -> load next cycle, count back to 0,
//    is_div 1; exactly one result_rdy, 34 cycles after the ctrl_div.
//  5 ctrl_mult and ctrl_div high together in IDLE -> start_err pulse next cycle,
//    state stays IDLE, is_div unchanged.
//  6 clr asserted with count==20 in RUN, together with a ctrl_mult -> IDLE and
//    count 0 next cycle, no load, no result_rdy.

Source files
------------

// File: rtl/multdiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: state encoding and
// the default step count and counter width.
package multdiv_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    localparam int N_STEPS_DEFAULT = 32;
    localparam int CNT_W_DEFAULT   = 6;

endpackage

// File: rtl/multdiv_sequencer_iter_counter.sv
// Iteration counter: synchronous clear, enable, and saturation at the
// terminal count N_STEPS-1, which is also flagged on tc_o.
module iter_counter #(
    parameter int N_STEPS = 32,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_STEPS - 1);

    logic [CNT_W-1:0] count_q;

    // The counter stops at LAST rather than wrapping, so a late enable is harmless.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else if (en_i && !tc_o) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o    = (count_q == LAST);
    assign count_o = count_q;

endmodule

// File: rtl/multdiv_sequencer.sv
// Control FSM that sequences an N_STEPS-iteration multiply/divide datapath:
// load pulse, per-step enable, op select and a one-cycle result-ready.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int N_STEPS = N_STEPS_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    output logic             busy,
    output logic             load,
    output logic             step,
    output logic             is_div,
    output logic [CNT_W-1:0] count,
    output logic             result_rdy,
    output logic             start_err
);

    state_e state_q, state_d;
    logic   start, both;
    logic   cnt_clr, cnt_en, tc;
    logic   busy_q, load_q, step_q, is_div_q, rdy_q, err_q;

    assign both  = ctrl_mult & ctrl_div;
    assign start = ctrl_mult ^ ctrl_div;

    // A start from any state (including LOAD/RUN) aborts and reloads;
    // conflicting starts freeze the FSM for that cycle.
    always_comb begin
        state_d = state_q;
        if (both) begin
            state_d = state_q;
        end else if (start) begin
            state_d = S_LOAD;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_LOAD:  state_d = S_RUN;
                S_RUN:   state_d = tc ? S_DONE : S_RUN;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cnt_clr = clr | (state_q == S_LOAD);
    assign cnt_en  = (state_q == S_RUN) & ~both;

    iter_counter #(
        .N_STEPS (N_STEPS),
        .CNT_W   (CNT_W)
    ) u_iter_counter (
        .clk     (clk),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (count),
        .tc_o    (tc)
    );

    // Outputs are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            load_q   <= 1'b0;
            step_q   <= 1'b0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            is_div_q <= 1'b0;
        end else begin
            state_q <= state_d;
            load_q  <= (state_d == S_LOAD);
            step_q  <= (state_d == S_RUN);
            busy_q  <= (state_d == S_LOAD) || (state_d == S_RUN);
            rdy_q   <= (state_d == S_DONE);
            err_q   <= both;
            if (start) begin
                is_div_q <= ctrl_div;
            end
        end
    end

    assign busy       = busy_q;
    assign load       = load_q;
    assign step       = step_q;
    assign is_div     = is_div_q;
    assign result_rdy = rdy_q;
    assign start_err  = err_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench: directed scenarios plus random pulses, compared every
// cycle against a timeline model (cycles elapsed since the last accepted start).
module tb_multdiv_sequencer;

    localparam int N = 32;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ctrl_mult = 1'b0;
    logic       ctrl_div = 1'b0;
    logic       busy, load, step, is_div, result_rdy, start_err;
    logic [5:0] count;

    int checks   = 0;
    int failures = 0;
    int rdy_seen = 0;

    // reference model: an op is a timeline measured in cycles since its start
    bit active = 0;
    int age = 0;
    bit m_isdiv = 0;
    bit m_err = 0;
    bit cnt_known = 0;
    int cnt_exp = 0;
    bit e_load, e_step, e_rdy;

    always #5 clk = ~clk;

    multdiv_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .ctrl_mult  (ctrl_mult),
        .ctrl_div   (ctrl_div),
        .busy       (busy),
        .load       (load),
        .step       (step),
        .is_div     (is_div),
        .count      (count),
        .result_rdy (result_rdy),
        .start_err  (start_err)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit c, input bit m, input bit d);
        if (c) begin
            active = 0; m_isdiv = 0; m_err = 0;
        end else begin
            m_err = m & d;
            if (m ^ d) begin
                active = 1; age = 1; m_isdiv = d;
            end else if (active && !(m & d)) begin
                age++;
                if (age > N + 2) active = 0;
            end
        end
        e_load = active && (age == 1);
        e_step = active && (age >= 2) && (age <= N + 1);
        e_rdy  = active && (age == N + 2);
        if (c) begin
            cnt_known = 1; cnt_exp = 0;
        end else if (e_step) begin
            cnt_known = 1; cnt_exp = age - 2;
        end else if (e_load) begin
            cnt_known = 0;
        end
    endtask

    task automatic tick(input bit c, input bit m, input bit d);
        @(negedge clk);
        clr = c; ctrl_mult = m; ctrl_div = d;
        @(posedge clk);
        model_update(c, m, d);
        #1;
        if (result_rdy === 1'b1) rdy_seen++;
        check_val("load", {31'd0, load}, {31'd0, e_load});
        check_val("step", {31'd0, step}, {31'd0, e_step});
        check_val("busy", {31'd0, busy}, {31'd0, e_load | e_step});
        check_val("result_rdy", {31'd0, result_rdy}, {31'd0, e_rdy});
        check_val("start_err", {31'd0, start_err}, {31'd0, m_err});
        check_val("is_div", {31'd0, is_div}, {31'd0, m_isdiv});
        if (cnt_known) check_val("count", {26'd0, count}, cnt_exp);
    endtask

    initial begin
        int guard;
        // 1: reset then quiet
        tick(1, 0, 0);
        tick(1, 0, 0);
        repeat (5) tick(0, 0, 0);
        check_val("t1_count_zero", {26'd0, count}, 32'd0);

        // 2: multiply, full run
        rdy_seen = 0;
        tick(0, 1, 0);
        repeat (40) tick(0, 0, 0);
        check_val("t2_rdy_pulses", rdy_seen, 1);

        // 3: divide, restart in DONE cycle
        rdy_seen = 0;
        tick(0, 0, 1);
        guard = 0;
        while (!e_rdy && guard < 100) begin tick(0, 0, 0); guard++; end
        check_val("t3_reached_done", {31'd0, e_rdy}, 32'd1);
        tick(0, 0, 1);
        repeat (40) tick(0, 0, 0);
        check_val("t3_rdy_pulses", rdy_seen, 2);

        // 4: abort multiply with divide at count 10
        rdy_seen = 0;
        tick(0, 1, 0);
        guard = 0;
        while (!(e_step && cnt_exp == 10) && guard < 100) begin tick(0, 0, 0); guard++; end
        check_val("t4_reached_cnt10", cnt_exp, 10);
        tick(0, 0, 1);
        repeat (40) tick(0, 0, 0);
        check_val("t4_rdy_pulses", rdy_seen, 1);
        check_val("t4_is_div", {31'd0, is_div}, 32'd1);

        // 5: conflicting starts while idle
        tick(0, 1, 1);
        tick(0, 0, 0);
        check_val("t5_idle", {31'd0, busy}, 32'd0);

        // 6: clr with a simultaneous start mid-run
        rdy_seen = 0;
        tick(0, 1, 0);
        guard = 0;
        while (!(e_step && cnt_exp == 20) && guard < 100) begin tick(0, 0, 0); guard++; end
        check_val("t6_reached_cnt20", cnt_exp, 20);
        tick(1, 1, 0);
        check_val("t6_count_cleared", {26'd0, count}, 32'd0);
        repeat (40) tick(0, 0, 0);
        check_val("t6_rdy_pulses", rdy_seen, 0);

        // random pulses; conflicting starts only while the model is idle
        for (int i = 0; i < 3000; i++) begin
            bit c, m, d;
            int r;
            c = ($urandom_range(0, 499) == 0);
            r = $urandom_range(0, 59);
            m = (r == 0);
            d = (r == 1);
            if (r == 2 && !active) begin m = 1; d = 1; end
            tick(c, m, d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
